// File: rtl/simon_btn_input.sv
// rtl/simon_btn_input.sv - Simon direction-button synchronizer, debouncer and press-event arbiter
// Four raw buttons become debounced levels, one-cycle pulses and a single validated press event.
module simon_btn_input #(
  parameter int DB_CYCLES = 2000000,
  parameter int CNT_W     = 21
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Enable,
  input  logic       Clr_Count,
  input  logic       Btn_U,
  input  logic       Btn_R,
  input  logic       Btn_D,
  input  logic       Btn_L,
  output logic [3:0] Btn_SCEN,
  output logic [3:0] Btn_Level,
  output logic       Btn_Valid,
  output logic [1:0] Btn_Code,
  output logic       Multi_Err,
  output logic [7:0] Press_Count
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    PULSE,
    HELD,
    REL_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [3:0]       raw;
  logic [3:0]       sync1_q;
  logic [3:0]       sync2_q;
  state_t           state_q [4];
  state_t           state_d [4];
  logic [CNT_W-1:0] cnt_q   [4];
  logic [CNT_W-1:0] cnt_d   [4];
  logic [3:0]       pulse;
  logic [3:0]       level;

  logic [2:0]       n_pulse;
  logic             hold_any;
  logic [1:0]       pulse_idx;
  logic             accept;
  logic             reject;

  logic             valid_q;
  logic             err_q;
  logic [1:0]       code_q;
  logic [7:0]       count_q;
  logic [7:0]       count_d;

  assign raw = {Btn_L, Btn_D, Btn_R, Btn_U};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge Clk) begin
    for (int i = 0; i < 4; i++) begin
      if (Reset) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end else begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Counter compare happens before increment, so cnt never passes DB_CYCLES-1.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      pulse[i]   = 1'b0;
      level[i]   = 1'b0;
      case (state_q[i])
        IDLE: begin
          if (sync2_q[i]) begin
            state_d[i] = PRESS_WAIT;
            cnt_d[i]   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync2_q[i]) begin
            state_d[i] = IDLE;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = PULSE;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        PULSE: begin
          pulse[i]   = 1'b1;
          level[i]   = 1'b1;
          state_d[i] = HELD;
        end
        HELD: begin
          level[i] = 1'b1;
          if (!sync2_q[i]) begin
            state_d[i] = REL_WAIT;
            cnt_d[i]   = '0;
          end
        end
        REL_WAIT: begin
          level[i] = 1'b1;
          if (sync2_q[i]) begin
            state_d[i] = HELD;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // A press is only accepted when it is the sole pulse and no other button is down.
  always_comb begin
    n_pulse   = '0;
    hold_any  = 1'b0;
    pulse_idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (pulse[i]) begin
        n_pulse   = n_pulse + 3'd1;
        pulse_idx = 2'(i);
      end else if (level[i]) begin
        hold_any = 1'b1;
      end
    end
  end

  assign accept = Enable && (n_pulse == 3'd1) && !hold_any;
  assign reject = Enable && ((n_pulse >= 3'd2) || ((n_pulse == 3'd1) && hold_any));

  always_comb begin
    count_d = count_q;
    if (Clr_Count) begin
      count_d = '0;
    end else if (accept && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= accept;
      err_q   <= reject;
      count_q <= count_d;
      if (accept) begin
        code_q <= pulse_idx;
      end
    end
  end

  assign Btn_SCEN    = pulse & {4{Enable}};
  assign Btn_Level   = level;
  assign Btn_Valid   = valid_q;
  assign Btn_Code    = code_q;
  assign Multi_Err   = err_q;
  assign Press_Count = count_q;

endmodule

// File: tb/tb_simon_btn_input.sv
// tb/tb_simon_btn_input.sv - self-checking bench for simon_btn_input against a stable-run model
module tb_simon_btn_input;

  localparam int DB = 4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Enable = 1'b1;
  logic       Clr_Count = 1'b0;
  logic       Btn_U = 1'b0;
  logic       Btn_R = 1'b0;
  logic       Btn_D = 1'b0;
  logic       Btn_L = 1'b0;
  logic [3:0] Btn_SCEN;
  logic [3:0] Btn_Level;
  logic       Btn_Valid;
  logic [1:0] Btn_Code;
  logic       Multi_Err;
  logic [7:0] Press_Count;

  simon_btn_input #(.DB_CYCLES(DB), .CNT_W(3)) dut (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .Clr_Count(Clr_Count),
    .Btn_U(Btn_U), .Btn_R(Btn_R), .Btn_D(Btn_D), .Btn_L(Btn_L),
    .Btn_SCEN(Btn_SCEN), .Btn_Level(Btn_Level), .Btn_Valid(Btn_Valid),
    .Btn_Code(Btn_Code), .Multi_Err(Multi_Err), .Press_Count(Press_Count)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: a button's debounced level flips once the synchronized input has
  // disagreed with it for DB+1 consecutive samples; the sample taken while
  // leaving the pulse cycle is ignored.
  bit [3:0] m_s1, m_s2, m_lvl, m_pulse;
  int       m_run [4];
  bit       m_valid, m_err;
  int       m_code, m_cnt;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit [3:0] raw;
    int       np;
    bit       h, acc, rej;
    raw = {Btn_L, Btn_D, Btn_R, Btn_U};
    if (Reset) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pulse = '0;
      for (int b = 0; b < 4; b++) m_run[b] = 0;
      m_valid = 0; m_err = 0; m_code = 0; m_cnt = 0;
    end else begin
      np  = $countones(m_pulse);
      h   = |(m_lvl & ~m_pulse);
      acc = Enable && np == 1 && !h;
      rej = Enable && (np >= 2 || (np == 1 && h));
      m_valid = acc;
      m_err   = rej;
      if (acc) for (int b = 0; b < 4; b++) if (m_pulse[b]) m_code = b;
      if (Clr_Count) m_cnt = 0;
      else if (acc && m_cnt < 255) m_cnt++;
      for (int b = 0; b < 4; b++) begin
        if (m_pulse[b]) begin
          m_pulse[b] = 0;
          m_run[b]   = 0;
        end else if (m_s2[b] != m_lvl[b]) begin
          m_run[b]++;
          if (m_run[b] == DB + 1) begin
            m_lvl[b]   = m_s2[b];
            m_pulse[b] = m_s2[b];
            m_run[b]   = 0;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    #1;
    chk("scen",  Btn_SCEN,    m_pulse & {4{Enable}});
    chk("level", Btn_Level,   m_lvl);
    chk("valid", Btn_Valid,   m_valid);
    chk("err",   Multi_Err,   m_err);
    chk("code",  Btn_Code,    m_code);
    chk("count", Press_Count, m_cnt);
  endtask

  task automatic set_btns(input bit [3:0] v);
    {Btn_L, Btn_D, Btn_R, Btn_U} = v;
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_count();
    Clr_Count = 1'b1;
    tick();
    Clr_Count = 1'b0;
  endtask

  int n_valid, n_err, n_both, n_scen, last_code;
  bit any_act;

  initial begin
    // reset state
    wait_n(2);
    chk("rst_scen",  Btn_SCEN, 0);
    chk("rst_level", Btn_Level, 0);
    chk("rst_valid", Btn_Valid, 0);
    chk("rst_cnt",   Press_Count, 0);
    Reset = 1'b0;
    wait_n(3);

    // clean press on R: pulse in cycle 6-7, event in cycle 7-8
    set_btns(4'b0010);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("clean_scen",  Btn_SCEN[1], (k == 6) ? 1 : 0);
      chk("clean_valid", Btn_Valid,   (k == 7) ? 1 : 0);
      if (k == 7) chk("clean_code", Btn_Code, 1);
    end
    chk("clean_cnt", Press_Count, 1);
    set_btns(4'b0000);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("clean_rel_level", Btn_Level[1], (k < 6) ? 1 : 0);
    end

    // bounce on U
    any_act = 0;
    for (int k = 0; k < 16; k++) begin
      set_btns((k < 8 && (k % 4) < 2) ? 4'b0001 : 4'b0000);
      tick();
      if (Btn_SCEN != 0 || Btn_Valid || Btn_Level != 0) any_act = 1;
    end
    chk("bounce_activity", any_act, 0);

    // chord: D then L
    clear_count();
    n_valid = 0; n_err = 0; last_code = -1;
    set_btns(4'b0100);
    for (int k = 0; k < 24; k++) begin
      if (k == 10) set_btns(4'b1100);
      tick();
      if (Btn_Valid) begin n_valid++; last_code = Btn_Code; end
      if (Multi_Err) n_err++;
    end
    chk("chord_valid", n_valid, 1);
    chk("chord_code",  last_code, 2);
    chk("chord_err",   n_err, 1);
    chk("chord_cnt",   Press_Count, 1);
    set_btns(4'b0000);
    wait_n(12);

    // simultaneous U and L
    n_valid = 0; n_err = 0; n_both = 0;
    set_btns(4'b1001);
    for (int k = 0; k < 14; k++) begin
      tick();
      if (Btn_SCEN == 4'b1001) n_both++;
      if (Btn_Valid) n_valid++;
      if (Multi_Err) n_err++;
      if (k == 7) chk("simul_err_next", Multi_Err, 1);
    end
    chk("simul_both", n_both, 1);
    chk("simul_err",  n_err, 1);
    chk("simul_valid", n_valid, 0);
    set_btns(4'b0000);
    wait_n(12);

    // press while disabled, enable while held, then reset while held
    clear_count();
    Enable = 1'b0;
    n_scen = 0; n_valid = 0;
    set_btns(4'b0010);
    for (int k = 0; k < 20; k++) begin
      if (k == 10) Enable = 1'b1;
      tick();
      if (Btn_SCEN != 0) n_scen++;
      if (Btn_Valid) n_valid++;
    end
    chk("dis_level", Btn_Level[1], 1);
    chk("dis_scen",  n_scen, 0);
    chk("dis_valid", n_valid, 0);
    Reset = 1'b1;
    tick();
    chk("rstmid_scen",  Btn_SCEN, 0);
    chk("rstmid_level", Btn_Level, 0);
    chk("rstmid_valid", Btn_Valid, 0);
    chk("rstmid_err",   Multi_Err, 0);
    chk("rstmid_code",  Btn_Code, 0);
    chk("rstmid_cnt",   Press_Count, 0);
    Reset = 1'b0;
    n_valid = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (Btn_Valid) n_valid++;
    end
    chk("requal_valid", n_valid, 1);
    chk("requal_cnt",   Press_Count, 1);
    set_btns(4'b0000);
    wait_n(10);

    // saturation
    clear_count();
    for (int p = 0; p < 257; p++) begin
      set_btns(4'b0001 << $urandom_range(0, 3));
      wait_n(8);
      set_btns(4'b0000);
      wait_n(8);
    end
    chk("sat_cnt", Press_Count, 255);
    set_btns(4'b0100);
    for (int k = 0; k < 9; k++) begin
      Clr_Count = (k == 7) ? 1'b1 : 1'b0;
      tick();
      if (k == 7) begin
        chk("clr_same_valid", Btn_Valid, 1);
        chk("clr_same_cnt",   Press_Count, 0);
      end
    end
    Clr_Count = 1'b0;
    set_btns(4'b0000);
    wait_n(10);

    // randomized traffic checked cycle by cycle against the model
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 5) == 0) set_btns(4'($urandom_range(0, 15)));
      else if ($urandom_range(0, 3) == 0) set_btns(4'b0001 << $urandom_range(0, 3));
      Enable    = ($urandom_range(0, 9) != 0);
      Clr_Count = ($urandom_range(0, 99) == 0);
      Reset     = ($urandom_range(0, 299) == 0);
      tick();
    end
    Reset = 1'b0;
    Clr_Count = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
